// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side streaming blocks.
// The output buffer occupancy is encoded as EMPTY, ONE or TWO entries.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_e;

    // Width of a counter that must reach n-1. It never drops below one bit,
    // so a burst length of 1 still gets a legal counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// skid_buf2: two-entry output buffer with an EMPTY/ONE/TWO occupancy FSM.
// The head register always holds the oldest entry and drives the stream data,
// so a presented beat stays stable until it is removed.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,    // a word enters the buffer this edge
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,    // the oldest word leaves this edge
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output occ_state_e        state
);

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;

    // Occupancy FSM, storage and the registered valid flag, all updated together.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    // NOTE: the two data registers are reset because the stream data output
    // must read zero while in reset; a larger RAM-style buffer would not be.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= EMPTY;
            valid <= 1'b0;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (wr_en) begin
                        state <= ONE;
                        valid <= 1'b1;
                        head  <= wr_data;
                    end
                end
                ONE: begin
                    if (wr_en && rd_en) begin
                        // Head leaves and the new word takes its place.
                        head <= wr_data;
                    end else if (wr_en) begin
                        state <= TWO;
                        tail  <= wr_data;
                    end else if (rd_en) begin
                        state <= EMPTY;
                        valid <= 1'b0;
                    end
                end
                TWO: begin
                    // The writer never pushes while full, so only a read matters.
                    if (rd_en) begin
                        state <= ONE;
                        head  <= tail;
                    end
                end
                default: begin
                    state <= EMPTY;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign data = head;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a zero-latency FIFO read port into a valid/ready
// stream, cutting it into bursts of BURST_LEN beats marked by o_m_last.
// Optional build macro FIFO_RD_STREAM_STATS_EN adds a 32-bit o_beat_total
// port counting accepted beats.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              o_fifo_rden,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    input  logic              i_fifo_empty,
    output logic              o_m_valid,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_last,
`ifdef FIFO_RD_STREAM_STATS_EN
    output logic [31:0]       o_beat_total,
`endif
    input  logic              i_m_ready
);

    localparam int              CNT_W     = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    occ_state_e       occ;
    logic             run_q;
    logic             hs;
    logic [CNT_W-1:0] beat_cnt;

    // Pops are held off for the first edge after reset release, so the FIFO
    // is never popped in the same cycle the block leaves reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) run_q <= 1'b0;
        else       run_q <= 1'b1;
    end

    // Pop whenever the FIFO has data and the buffer has a free slot.
    assign o_fifo_rden = run_q && !i_fifo_empty && (occ != TWO);
    assign hs          = o_m_valid && i_m_ready;

    skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (o_fifo_rden),
        .wr_data (i_fifo_rddata),
        .rd_en   (hs),
        .valid   (o_m_valid),
        .data    (o_m_data),
        .state   (occ)
    );

    // Beat position within the burst; advances only on accepted beats, so a
    // FIFO underrun stalls the burst rather than shortening it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt <= '0;
        end else if (hs) begin
            if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
            else                       beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    assign o_m_last = o_m_valid && (beat_cnt == LAST_BEAT);

`ifdef FIFO_RD_STREAM_STATS_EN
    // Running total of accepted beats, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   o_beat_total <= '0;
        else if (hs) o_beat_total <= o_beat_total + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream (DATA_W=4, BURST_LEN=4). The FIFO feeding
// the block is modelled by the queue my_fifo; accepted beats are collected and
// compared against hand-written expected sequences.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       o_fifo_rden;
    logic [3:0] i_fifo_rddata = '0;
    logic       i_fifo_empty = 1'b1;
    logic       o_m_valid;
    logic [3:0] o_m_data;
    logic       o_m_last;
    logic       i_m_ready = 1'b0;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] o_beat_total;
`endif

    fifo_rd_stream #(
        .DATA_W    (4),
        .BURST_LEN (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .o_fifo_rden   (o_fifo_rden),
        .i_fifo_rddata (i_fifo_rddata),
        .i_fifo_empty  (i_fifo_empty),
        .o_m_valid     (o_m_valid),
        .o_m_data      (o_m_data),
        .o_m_last      (o_m_last),
`ifdef FIFO_RD_STREAM_STATS_EN
        .o_beat_total  (o_beat_total),
`endif
        .i_m_ready     (i_m_ready)
    );

    always #5 clk = ~clk;

    logic [3:0] my_fifo[$];
    logic [3:0] rx_data[$];
    logic       rx_last[$];
    int         rx_cyc[$];
    logic [3:0] exp_d[$];
    logic       exp_l[$];
    int         cyc       = 0;
    int         pop_cnt   = 0;
    int         rden_viol = 0;
    int         n_checks  = 0;
    int         n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fifo_drive();
        i_fifo_empty  = (my_fifo.size() == 0);
        i_fifo_rddata = (my_fifo.size() == 0) ? 4'h0 : my_fifo[0];
    endtask

    task automatic push_words(input int first, input int count);
        for (int i = 0; i < count; i++) my_fifo.push_back(4'(first + i));
        fifo_drive();
    endtask

    // One clock: observe at the falling edge, apply the pop just after the rising edge.
    task automatic cycle();
        logic pop;
        @(negedge clk);
        pop = o_fifo_rden;
        if (o_fifo_rden && i_fifo_empty) rden_viol++;
        if (pop) pop_cnt++;
        if (o_m_valid && i_m_ready) begin
            rx_data.push_back(o_m_data);
            rx_last.push_back(o_m_last);
            rx_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop && my_fifo.size() > 0) void'(my_fifo.pop_front());
        fifo_drive();
    endtask

    task automatic drain(input string tag, input bit toggle, input int max_cyc);
        int n = 0;
        while ((my_fifo.size() != 0 || o_m_valid) && n < max_cyc) begin
            if (toggle) i_m_ready = ~i_m_ready;
            cycle();
            n++;
        end
        check({tag, "_drained"}, 32'((my_fifo.size() == 0) && !o_m_valid), 32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_m_ready = 1'b0;
        cycle();
        cycle();
        my_fifo.delete();
        fifo_drive();
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
        pop_cnt   = 0;
        rden_viol = 0;
        rstn = 1'b1;
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, 32'(rx_data.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < rx_data.size(); i++) begin
            check($sformatf("%s_data[%0d]", tag, i), 32'(rx_data[i]), 32'(exp_d[i]));
            check($sformatf("%s_last[%0d]", tag, i), 32'(rx_last[i]), 32'(exp_l[i]));
        end
        check({tag, "_rden_empty"}, 32'(rden_viol), 32'd0);
    endtask

    initial begin
        // Reset state, visible while rstn is held low.
        #1;
        check("rst_valid", 32'(o_m_valid), 32'd0);
        check("rst_last",  32'(o_m_last),  32'd0);
        check("rst_rden",  32'(o_fifo_rden), 32'd0);
        check("rst_data",  32'(o_m_data),  32'd0);

        // S1: 8 words, ready held high -> back-to-back beats, last on 0x4 and 0x8.
        do_reset();
        push_words(1, 8);
        i_m_ready = 1'b1;
        drain("s1", 1'b0, 40);
        exp_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        check_rx("s1");
        for (int i = 1; i < rx_cyc.size(); i++)
            check($sformatf("s1_gap[%0d]", i), 32'(rx_cyc[i] - rx_cyc[i-1]), 32'd1);

        // S2: 6 words with ready low for 10 cycles -> only 2 pops, head holds 0x1.
        do_reset();
        push_words(1, 6);
        repeat (10) cycle();
        check("s2_pops",  32'(pop_cnt), 32'd2);
        check("s2_valid", 32'(o_m_valid), 32'd1);
        check("s2_hold",  32'(o_m_data), 32'h1);
        check("s2_fifo_left", 32'(my_fifo.size()), 32'd4);
        i_m_ready = 1'b1;
        drain("s2", 1'b0, 40);
        exp_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        check_rx("s2");

        // S3: ready toggles every cycle over 12 words -> no loss, last on 4/8/12.
        do_reset();
        push_words(1, 12);
        drain("s3", 1'b1, 80);
        exp_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        check_rx("s3");

        // S4: 2 words, FIFO empty 5 cycles, 2 more -> last only on the 4th word.
        do_reset();
        i_m_ready = 1'b1;
        push_words(1, 2);
        repeat (4) cycle();
        repeat (5) cycle();
        check("s4_gap_valid", 32'(o_m_valid), 32'd0);
        check("s4_gap_count", 32'(rx_data.size()), 32'd2);
        push_words(3, 2);
        cycle();
        // Word at the head while the buffer was empty is presented one edge later.
        check("s4_latency_valid", 32'(o_m_valid), 32'd1);
        check("s4_latency_data",  32'(o_m_data),  32'h3);
        drain("s4", 1'b0, 40);
        exp_d = '{4'h1, 4'h2, 4'h3, 4'h4};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        check_rx("s4");

        // S5: reset after 2 of 4 beats with one word buffered.
        do_reset();
        push_words(1, 3);
        repeat (3) cycle();
        i_m_ready = 1'b1;
        cycle();
        cycle();
        i_m_ready = 1'b0;
        check("s5_pre_count", 32'(rx_data.size()), 32'd2);
        check("s5_pre_head",  32'(o_m_data), 32'h3);
        push_words(15, 1);
        rstn = 1'b0;
        #1;
        check("s5_rst_valid", 32'(o_m_valid), 32'd0);
        check("s5_rst_last",  32'(o_m_last),  32'd0);
        check("s5_rst_data",  32'(o_m_data),  32'd0);
        check("s5_rst_rden",  32'(o_fifo_rden), 32'd0);
        cycle();
        my_fifo.delete();
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
        push_words(10, 4);
        rstn = 1'b1;
        #1;
        check("s5_release_rden", 32'(o_fifo_rden), 32'd0);
        i_m_ready = 1'b1;
        drain("s5", 1'b0, 40);
        exp_d = '{4'hA, 4'hB, 4'hC, 4'hD};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        check_rx("s5");

`ifdef FIFO_RD_STREAM_STATS_EN
        // S6: 9 accepted beats counted, cleared again by reset.
        do_reset();
        push_words(1, 9);
        i_m_ready = 1'b1;
        drain("s6", 1'b0, 40);
        check("s6_total", o_beat_total, 32'd9);
        rstn = 1'b0;
        #1;
        check("s6_total_rst", o_beat_total, 32'd0);
        rstn = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
